segre_mm_arbiter: RTL and testbench
===================================

Name: segre_mm_arbiter

Overview:
- Parametrised main-memory arbiter. Successor to the fixed two-client ($I/$D) main-memory path inside the MMU.
- Serves NUM_PORTS cache/requester ports over a single main-memory channel. Round-robin fairness; one outstanding transaction at a time.
- Supports combined write-back + refill requests.
- Sits between the cache miss logic and the core's mm_* pins.

Parameters:
NUM_PORTS, 2, number of requester ports (>=1)
ADDR_SIZE, 32, address width
WORD_SIZE, 32, store data width
LANE_SIZE, 128, cache line width returned on reads
IDX_W, (NUM_PORTS>1 ? $clog2(NUM_PORTS) : 1), port index width (derived, not overridden)

Ports:
clk_i  in  1  clock
rsn_i  in  1  reset; synchronous, active-high (1 = reset)
req_rd_i  in  NUM_PORTS  per-port read (line refill) request, level
req_wr_i  in  NUM_PORTS  per-port write request, level
req_addr_i  in  NUM_PORTS*ADDR_SIZE  per-port address, port p at [p*ADDR_SIZE +: ADDR_SIZE]
req_wr_data_i  in  NUM_PORTS*WORD_SIZE  per-port store data
req_wr_type_i  in  NUM_PORTS*2  per-port memop_data_type_e (byte/half/word)
rsp_rdy_o  out  NUM_PORTS  one-hot, one-cycle completion pulse
rsp_data_o  out  LANE_SIZE  read line, valid while rsp_rdy_o != 0 after a read
grant_o  out  NUM_PORTS  one-hot, port currently owning main memory
busy_o  out  1  transaction in flight (state != IDLE)
mm_rd_o  out  1  main-memory read request
mm_wr_o  out  1  main-memory write request
mm_addr_o  out  ADDR_SIZE  main-memory address
mm_wr_data_o  out  WORD_SIZE  main-memory write data
mm_wr_data_type_o  out  2  main-memory write size
mm_data_rdy_i  in  1  main-memory completion, one-cycle pulse
mm_rd_data_i  in  LANE_SIZE  main-memory read line

Behaviour:
- All outputs are registered.
- Reset value of every output and internal register is 0: state IDLE, rr_ptr 0, no latched request.

Requester handshake:
- Requester holds req_rd/req_wr, addr, data and type stable until it sees its rsp_rdy_o bit.
- Requester deasserts on the clock edge that ends the pulse cycle.

FSM states: IDLE, WR, RD, RESP.

IDLE:
- Pending set = req_rd_i | req_wr_i.
- If non-empty, winner = first pending port searching rr_ptr, rr_ptr+1, ... with wrap at NUM_PORTS-1 -> 0.
- Latch the winner's index, addr, data, type and rd/wr bits. Set grant_o[winner].
- If wr is latched, next state is WR; otherwise RD.
- Empty pending set: stay in IDLE, all outputs 0.

WR:
- mm_wr_o=1 with latched addr, data and type, held until mm_data_rdy_i=1.
- On mm_data_rdy_i: drop mm_wr_o. If rd is also latched, next state is RD (same grant, no re-arbitration); otherwise RESP.

RD:
- mm_rd_o=1 with latched addr, held until mm_data_rdy_i=1.
- On mm_data_rdy_i: capture mm_rd_data_i into rsp_data_o, drop mm_rd_o, next state RESP.

RESP (exactly one cycle):
- rsp_rdy_o[idx]=1.
- rr_ptr <= (idx==NUM_PORTS-1) ? 0 : idx+1.
- grant_o cleared. Next state IDLE.

Latency and ordering:
- Minimum latency from a request seen in IDLE to rsp_rdy_o: 1 (IDLE) + memory cycles + 1 (RESP).
- A write-only request's pulse does not change rsp_data_o.
- Combined rd+wr from one port: write first, then read. A single pulse is issued after the read.

Fairness:
- A continuously requesting port waits at most NUM_PORTS-1 other transactions.

Boundary conditions:
- mm_data_rdy_i in IDLE or RESP is ignored.
- mm_data_rdy_i coincident with entry to WR/RD (the cycle mm_*_o first rises) is still accepted.
- Request changes on a non-granted port mid-transaction have no effect on the current transaction.
- NUM_PORTS=1: rr_ptr stays 0.
- Reset asserted mid-transaction: next edge forces IDLE, all outputs 0, and no rsp_rdy_o pulse. Main memory must abandon the transaction.

Test Plan:
- Single read: port0 req_rd, addr 0x100; mm_data_rdy_i pulsed 3 cycles after mm_rd_o rises with data 0xDEADBEEF_...; expect mm_addr_o=0x100, then rsp_rdy_o=01 one cycle after rdy with rsp_data_o equal to the line; busy_o low the following cycle.
- Contention: NUM_PORTS=4, ports 1 and 3 request together after reset; expect port1 served first, then port3; rr_ptr then 0 so port0 wins a subsequent 0/2 tie.
- Starvation: ports 0..3 all requesting continuously; expect grant order 0,1,2,3,0 with exactly one rsp_rdy_o pulse each.
- Combined write-back + refill: port2 rd+wr, addr 0x40, data 0x12345678, type word; expect mm_wr_o first, then mm_rd_o, with no IDLE cycle in between and a single rsp_rdy_o[2] pulse.
- Reset mid-read: assert rsn_i while in RD; expect mm_rd_o=0, grant_o=0, rsp_rdy_o=0 next cycle. After release, a fresh request is served normally from rr_ptr=0.
- Spurious ready: mm_data_rdy_i pulsed in IDLE; expect no state change and no rsp_rdy_o.

Source files
------------

// File: rtl/segre_mm_arbiter.sv
// segre_mm_arbiter: round-robin arbiter giving NUM_PORTS requesters access to
// a single main-memory channel, one transaction at a time. A combined
// write-back + refill request runs the write, then the read, under one grant.
//
// state | meaning
// IDLE  | no transaction; arbitrate among pending ports
// WR    | mm_wr_o asserted, waiting for mm_data_rdy_i
// RD    | mm_rd_o asserted, waiting for mm_data_rdy_i
// RESP  | one-cycle rsp_rdy_o pulse to the owning port
module segre_mm_arbiter #(
  parameter  int NUM_PORTS = 2,
  parameter  int ADDR_SIZE = 32,
  parameter  int WORD_SIZE = 32,
  parameter  int LANE_SIZE = 128,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                           clk_i,
  input  logic                           rsn_i,
  input  logic [NUM_PORTS-1:0]           req_rd_i,
  input  logic [NUM_PORTS-1:0]           req_wr_i,
  input  logic [NUM_PORTS*ADDR_SIZE-1:0] req_addr_i,
  input  logic [NUM_PORTS*WORD_SIZE-1:0] req_wr_data_i,
  input  logic [NUM_PORTS*2-1:0]         req_wr_type_i,
  output logic [NUM_PORTS-1:0]           rsp_rdy_o,
  output logic [LANE_SIZE-1:0]           rsp_data_o,
  output logic [NUM_PORTS-1:0]           grant_o,
  output logic                           busy_o,
  output logic                           mm_rd_o,
  output logic                           mm_wr_o,
  output logic [ADDR_SIZE-1:0]           mm_addr_o,
  output logic [WORD_SIZE-1:0]           mm_wr_data_o,
  output logic [1:0]                     mm_wr_data_type_o,
  input  logic                           mm_data_rdy_i,
  input  logic [LANE_SIZE-1:0]           mm_rd_data_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = NUM_PORTS'(1);

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] idx_q;
  logic             rd_q;

  logic [NUM_PORTS-1:0] pending;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  int                   cand;

  // Round-robin search: first pending port starting at rr_ptr, wrapping to 0.
  always_comb begin
    pending   = req_rd_i | req_wr_i;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!win_found && pending[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      idx_q             <= '0;
      rd_q              <= 1'b0;
      rsp_rdy_o         <= '0;
      rsp_data_o        <= '0;
      grant_o           <= '0;
      busy_o            <= 1'b0;
      mm_rd_o           <= 1'b0;
      mm_wr_o           <= 1'b0;
      mm_addr_o         <= '0;
      mm_wr_data_o      <= '0;
      mm_wr_data_type_o <= '0;
    end else begin
      rsp_rdy_o <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            idx_q     <= win_idx;
            rd_q      <= req_rd_i[win_idx];
            grant_o   <= ONE_HOT0 << win_idx;
            busy_o    <= 1'b1;
            mm_addr_o <= req_addr_i[win_idx*ADDR_SIZE +: ADDR_SIZE];
            if (req_wr_i[win_idx]) begin
              mm_wr_o           <= 1'b1;
              mm_wr_data_o      <= req_wr_data_i[win_idx*WORD_SIZE +: WORD_SIZE];
              mm_wr_data_type_o <= req_wr_type_i[win_idx*2 +: 2];
              state             <= WR;
            end else begin
              mm_rd_o <= 1'b1;
              state   <= RD;
            end
          end
        end
        WR: begin
          if (mm_data_rdy_i) begin
            mm_wr_o           <= 1'b0;
            mm_wr_data_o      <= '0;
            mm_wr_data_type_o <= '0;
            if (rd_q) begin
              // Refill follows the write-back directly, keeping the grant.
              mm_rd_o <= 1'b1;
              state   <= RD;
            end else begin
              rsp_rdy_o <= ONE_HOT0 << idx_q;
              state     <= RESP;
            end
          end
        end
        RD: begin
          if (mm_data_rdy_i) begin
            rsp_data_o <= mm_rd_data_i;
            mm_rd_o    <= 1'b0;
            rsp_rdy_o  <= ONE_HOT0 << idx_q;
            state      <= RESP;
          end
        end
        RESP: begin
          rr_ptr    <= (idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : idx_q + 1'b1;
          grant_o   <= '0;
          busy_o    <= 1'b0;
          mm_addr_o <= '0;
          rd_q      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_segre_mm_arbiter.sv
// Directed bench for segre_mm_arbiter with four ports.
module tb_segre_mm_arbiter;

  localparam int NP = 4;

  logic          clk_i = 1'b0;
  logic          rsn_i;
  logic [NP-1:0] req_rd_i;
  logic [NP-1:0] req_wr_i;
  logic [NP*32-1:0] req_addr_i;
  logic [NP*32-1:0] req_wr_data_i;
  logic [NP*2-1:0]  req_wr_type_i;
  logic [NP-1:0] rsp_rdy_o;
  logic [127:0]  rsp_data_o;
  logic [NP-1:0] grant_o;
  logic          busy_o;
  logic          mm_rd_o;
  logic          mm_wr_o;
  logic [31:0]   mm_addr_o;
  logic [31:0]   mm_wr_data_o;
  logic [1:0]    mm_wr_data_type_o;
  logic          mm_data_rdy_i;
  logic [127:0]  mm_rd_data_i;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] LINE_A = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] LINE_B = 128'h11112222_33334444_55556666_77778888;

  segre_mm_arbiter #(.NUM_PORTS(NP)) dut (
    .clk_i            (clk_i),
    .rsn_i            (rsn_i),
    .req_rd_i         (req_rd_i),
    .req_wr_i         (req_wr_i),
    .req_addr_i       (req_addr_i),
    .req_wr_data_i    (req_wr_data_i),
    .req_wr_type_i    (req_wr_type_i),
    .rsp_rdy_o        (rsp_rdy_o),
    .rsp_data_o       (rsp_data_o),
    .grant_o          (grant_o),
    .busy_o           (busy_o),
    .mm_rd_o          (mm_rd_o),
    .mm_wr_o          (mm_wr_o),
    .mm_addr_o        (mm_addr_o),
    .mm_wr_data_o     (mm_wr_data_o),
    .mm_wr_data_type_o(mm_wr_data_type_o),
    .mm_data_rdy_i    (mm_data_rdy_i),
    .mm_rd_data_i     (mm_rd_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rsn_i = 1'b1;
    tick();
    tick();
    rsn_i = 1'b0;
  endtask

  // Serve one read already requested by 'port'. 'delay' idle cycles of
  // memory before the ready pulse; 'drop' releases the request at the pulse.
  task automatic serve_rd(input string tag, input int port, input logic [31:0] addr,
                          input logic [127:0] line, input int delay, input bit drop);
    logic [NP-1:0] oh;
    oh = NP'(1) << port;
    tick();
    check({tag, "_grant"}, 128'(grant_o), 128'(oh));
    check({tag, "_mm_rd"}, 128'(mm_rd_o), 128'd1);
    check({tag, "_addr"}, 128'(mm_addr_o), 128'(addr));
    for (int i = 0; i < delay; i++) begin
      tick();
      check({tag, "_rsp_wait"}, 128'(rsp_rdy_o), 128'd0);
    end
    mm_data_rdy_i = 1'b1;
    mm_rd_data_i  = line;
    tick();
    mm_data_rdy_i = 1'b0;
    check({tag, "_rsp"}, 128'(rsp_rdy_o), 128'(oh));
    check({tag, "_data"}, rsp_data_o, line);
    check({tag, "_rd_drop"}, 128'(mm_rd_o), 128'd0);
    if (drop) req_rd_i[port] = 1'b0;
    tick();
    check({tag, "_rsp_end"}, 128'(rsp_rdy_o), 128'd0);
    check({tag, "_busy_end"}, 128'(busy_o), 128'd0);
    check({tag, "_grant_end"}, 128'(grant_o), 128'd0);
  endtask

  initial begin
    rsn_i         = 1'b1;
    req_rd_i      = '0;
    req_wr_i      = '0;
    req_addr_i    = '0;
    req_wr_data_i = '0;
    req_wr_type_i = '0;
    mm_data_rdy_i = 1'b0;
    mm_rd_data_i  = '0;
    do_reset();

    // Reset state
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_grant", 128'(grant_o), 128'd0);
    check("rst_rsp", 128'(rsp_rdy_o), 128'd0);
    check("rst_mm", {mm_rd_o, mm_wr_o, mm_addr_o, mm_wr_data_o, mm_wr_data_type_o}, 128'd0);
    check("rst_data", rsp_data_o, 128'd0);

    // Single read, ready 3 cycles after mm_rd_o rises
    req_addr_i[0*32 +: 32] = 32'h100;
    req_rd_i[0] = 1'b1;
    serve_rd("single", 0, 32'h100, LINE_A, 2, 1'b1);

    // Contention: ports 1 and 3 after reset, then a 0/2 tie with rr_ptr 0
    do_reset();
    req_addr_i[1*32 +: 32] = 32'h1000;
    req_addr_i[3*32 +: 32] = 32'h3000;
    req_rd_i = 4'b1010;
    serve_rd("cont_p1", 1, 32'h1000, LINE_B, 0, 1'b1);
    serve_rd("cont_p3", 3, 32'h3000, LINE_A, 1, 1'b1);
    req_addr_i[0*32 +: 32] = 32'h0200;
    req_addr_i[2*32 +: 32] = 32'h2000;
    req_rd_i = 4'b0101;
    serve_rd("tie_p0", 0, 32'h0200, LINE_B, 0, 1'b1);
    serve_rd("tie_p2", 2, 32'h2000, LINE_A, 0, 1'b1);

    // Starvation: all ports requesting continuously
    do_reset();
    req_rd_i = 4'b1111;
    serve_rd("starv0", 0, 32'h0200, LINE_A, 0, 1'b0);
    serve_rd("starv1", 1, 32'h1000, LINE_B, 0, 1'b0);
    serve_rd("starv2", 2, 32'h2000, LINE_A, 0, 1'b0);
    serve_rd("starv3", 3, 32'h3000, LINE_B, 0, 1'b0);
    serve_rd("starv0b", 0, 32'h0200, LINE_A, 0, 1'b0);
    req_rd_i = '0;

    // Combined write-back + refill on port 2
    req_addr_i[2*32 +: 32]    = 32'h40;
    req_wr_data_i[2*32 +: 32] = 32'h12345678;
    req_wr_type_i[2*2 +: 2]   = 2'b10;
    req_rd_i[2] = 1'b1;
    req_wr_i[2] = 1'b1;
    tick();
    check("comb_grant", 128'(grant_o), 128'h4);
    check("comb_wr", {mm_wr_o, mm_rd_o}, 128'b10);
    check("comb_wr_addr", 128'(mm_addr_o), 128'h40);
    check("comb_wr_data", 128'(mm_wr_data_o), 128'h12345678);
    check("comb_wr_type", 128'(mm_wr_data_type_o), 128'b10);
    tick();
    check("comb_wr_hold", {mm_wr_o, mm_rd_o}, 128'b10);
    mm_data_rdy_i = 1'b1;
    tick();
    mm_data_rdy_i = 1'b0;
    check("comb_rd", {mm_wr_o, mm_rd_o}, 128'b01);
    check("comb_no_rsp", 128'(rsp_rdy_o), 128'd0);
    check("comb_grant_kept", {busy_o, grant_o}, 128'h14);
    mm_data_rdy_i = 1'b1;
    mm_rd_data_i  = LINE_B;
    tick();
    mm_data_rdy_i = 1'b0;
    check("comb_rsp", 128'(rsp_rdy_o), 128'h4);
    check("comb_data", rsp_data_o, LINE_B);
    req_rd_i[2] = 1'b0;
    req_wr_i[2] = 1'b0;
    tick();
    check("comb_rsp_end", {busy_o, rsp_rdy_o, grant_o}, 128'd0);

    // Write-only on port 1 leaves rsp_data_o untouched
    req_addr_i[1*32 +: 32]    = 32'h80;
    req_wr_data_i[1*32 +: 32] = 32'hA5;
    req_wr_type_i[1*2 +: 2]   = 2'b00;
    req_wr_i[1] = 1'b1;
    tick();
    check("wo_wr", {mm_wr_o, mm_rd_o, grant_o}, 128'b10_0010);
    mm_data_rdy_i = 1'b1;
    mm_rd_data_i  = LINE_A;
    tick();
    mm_data_rdy_i = 1'b0;
    check("wo_rsp", 128'(rsp_rdy_o), 128'h2);
    check("wo_data_kept", rsp_data_o, LINE_B);
    check("wo_mm_idle", {mm_wr_o, mm_rd_o}, 128'd0);
    req_wr_i[1] = 1'b0;
    tick();
    check("wo_end", {busy_o, rsp_rdy_o}, 128'd0);

    // Reset mid-read on port 3 (rr_ptr is 2 here, so port 3 would win next)
    req_rd_i[3] = 1'b1;
    tick();
    check("rst_mid_rd", 128'(mm_rd_o), 128'd1);
    tick();
    rsn_i = 1'b1;
    tick();
    check("rst_mid_out", {mm_rd_o, grant_o, rsp_rdy_o, busy_o}, 128'd0);
    rsn_i = 1'b0;
    req_rd_i[0] = 1'b1;
    serve_rd("post_rst_p0", 0, 32'h0200, LINE_A, 0, 1'b1);
    serve_rd("post_rst_p3", 3, 32'h3000, LINE_B, 0, 1'b1);

    // Spurious ready in IDLE
    mm_data_rdy_i = 1'b1;
    mm_rd_data_i  = LINE_A;
    tick();
    mm_data_rdy_i = 1'b0;
    check("spur_out", {busy_o, rsp_rdy_o, mm_rd_o, mm_wr_o, grant_o}, 128'd0);
    check("spur_data", rsp_data_o, LINE_B);
    tick();
    check("spur_after", {busy_o, rsp_rdy_o, grant_o}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
